// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch : instruction fetch stage
//
// Owns the program counter, fetches one INST_W-bit word at a time from
// instruction memory and presents it to decode. Only one memory request is
// ever outstanding. A one-entry skid buffer catches a response that lands
// while decode is stalled, and a redirect (branch/jump) flushes everything
// and discards any response still in flight.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   imem_req_o          fetch request valid (REQ state only)
//   imem_addr_o         word address of the request (the current pc)
//   imem_gnt_i          request accepted when imem_req_o & imem_gnt_i
//   imem_rvalid_i       response valid, in order, >= 1 cycle after grant
//   imem_rdata_i        response instruction word
//   id_stall_i          decode cannot take the presented instruction
//   branch_en_i         one-cycle redirect pulse
//   branch_target_i     redirect pc
//   if_valid_o          if_pc_o/if_inst_o carry a real instruction
//   if_pc_o             fetch address of the presented instruction
//   if_inst_o           presented instruction, 0 (NOP) when not valid
//
// Handshakes
//   Memory side: a request transfers on a cycle where imem_req_o and
//   imem_gnt_i are both high; imem_addr_o may change while ungranted.
//   The response needs no ready: it is accepted on any cycle imem_rvalid_i
//   is high while a fetch is outstanding.
//   Decode side: an instruction is taken on a cycle where if_valid_o is high
//   and id_stall_i is low; while id_stall_i is high the outputs hold.
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                INST_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  input  logic              id_stall_i,
  input  logic              branch_en_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o
);

  // IDLE : one cycle after reset
  // REQ  : request pc, wait for grant
  // WAIT : one fetch outstanding, or (skid full) holding off new requests
  // DROP : one fetch outstanding whose response must be thrown away
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_e;

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] pc_q,        pc_d;
  logic [ADDR_W-1:0] fetch_pc_q,  fetch_pc_d;   // address of the outstanding fetch

  // Output slot (what decode sees)
  logic              slot_v_q,    slot_v_d;
  logic [ADDR_W-1:0] slot_pc_q,   slot_pc_d;
  logic [INST_W-1:0] slot_inst_q, slot_inst_d;

  // Skid buffer
  logic              skid_v_q,    skid_v_d;
  logic [ADDR_W-1:0] skid_pc_q,   skid_pc_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;

  logic consumed;
  logic slot_free;
  logic rsp_take;

  assign consumed  = slot_v_q & ~id_stall_i;
  assign slot_free = ~slot_v_q | consumed;

  // A response is only real in WAIT with the skid empty: with the skid full
  // WAIT is just holding off requests and nothing is outstanding.
  assign rsp_take  = (state_q == WAIT) & imem_rvalid_i & ~skid_v_q;

  // ---------------------------------------------------------------------------
  // Slot / skid routing
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_v_d    = slot_v_q;
    slot_pc_d   = slot_pc_q;
    slot_inst_d = slot_inst_q;
    skid_v_d    = skid_v_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;

    if (branch_en_i) begin
      // Redirect flushes both entries regardless of id_stall; if_pc is left
      // alone because it is meaningless while if_valid is low.
      slot_v_d    = 1'b0;
      slot_inst_d = '0;
      skid_v_d    = 1'b0;
    end else if (slot_free) begin
      if (skid_v_q) begin
        // Older word first. No response can coincide: no request was made
        // while the skid was full.
        slot_v_d    = 1'b1;
        slot_pc_d   = skid_pc_q;
        slot_inst_d = skid_inst_q;
        skid_v_d    = 1'b0;
      end else if (rsp_take) begin
        slot_v_d    = 1'b1;
        slot_pc_d   = fetch_pc_q;
        slot_inst_d = imem_rdata_i;
      end else if (consumed) begin
        slot_v_d    = 1'b0;
        slot_inst_d = '0;
      end
    end else if (rsp_take) begin
      // Slot is full and decode is stalled: park the response.
      skid_v_d    = 1'b1;
      skid_pc_d   = fetch_pc_q;
      skid_inst_d = imem_rdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state, pc and memory request
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_pc_d  = fetch_pc_q;
    imem_req_o  = 1'b0;
    imem_addr_o = pc_q;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (branch_en_i) pc_d = branch_target_i;
      end

      REQ: begin
        imem_req_o = 1'b1;
        if (branch_en_i) begin
          pc_d = branch_target_i;
          // A grant this cycle fetched the old pc; its answer is stale.
          if (imem_gnt_i) state_d = DROP;
        end else if (imem_gnt_i) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + ADDR_W'(1);
          state_d    = WAIT;
        end
      end

      WAIT: begin
        if (branch_en_i) begin
          pc_d = branch_target_i;
          // Nothing left in flight if the response is here now or if we were
          // only holding for the skid; otherwise the answer must be dropped.
          state_d = (imem_rvalid_i | skid_v_q) ? REQ : DROP;
        end else if (skid_v_q | imem_rvalid_i) begin
          // Request again only once the skid is empty after this cycle.
          state_d = skid_v_d ? WAIT : REQ;
        end
      end

      DROP: begin
        if (branch_en_i)   pc_d    = branch_target_i;
        if (imem_rvalid_i) state_d = REQ;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      fetch_pc_q  <= RESET_PC;
      slot_v_q    <= 1'b0;
      slot_pc_q   <= '0;
      slot_inst_q <= '0;
      skid_v_q    <= 1'b0;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_pc_q  <= fetch_pc_d;
      slot_v_q    <= slot_v_d;
      slot_pc_q   <= slot_pc_d;
      slot_inst_q <= slot_inst_d;
      skid_v_q    <= skid_v_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

  assign if_valid_o = slot_v_q;
  assign if_pc_o    = slot_pc_q;
  assign if_inst_o  = slot_inst_q;

endmodule
